// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: serialises CRT fetches and 6800 CPU accesses
// with fixed memory read latency and strict alternation under contention.
module vram_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       VAD,
  input  logic              vram_cs,
  output logic              vram_complete,
  output logic [7:0]        VDI,
  input  logic [15:0]       cpu_ad,
  input  logic [7:0]        cpu_di,
  output logic [7:0]        cpu_do,
  input  logic              cpu_rw,
  input  logic              cpu_cs,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_en,
  output logic              mem_we
);

  typedef enum logic [2:0] {
    IDLE,
    VID_ACC,
    VID_DONE,
    CPU_ACC,
    CPU_DONE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t            state_reg, state_next;
  logic              last_vid_reg, last_vid_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [7:0]        vdi_reg, vdi_next;
  logic              vram_complete_reg, vram_complete_next;
  logic [7:0]        cpu_do_reg, cpu_do_next;
  logic              cpu_ready_reg, cpu_ready_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_we_reg, mem_we_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      last_vid_reg      <= 1'b0;
      cnt_reg           <= 3'd0;
      vdi_reg           <= 8'h00;
      vram_complete_reg <= 1'b0;
      cpu_do_reg        <= 8'h00;
      cpu_ready_reg     <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= 8'h00;
      mem_en_reg        <= 1'b0;
      mem_we_reg        <= 1'b0;
    end else begin
      state_reg         <= state_next;
      last_vid_reg      <= last_vid_next;
      cnt_reg           <= cnt_next;
      vdi_reg           <= vdi_next;
      vram_complete_reg <= vram_complete_next;
      cpu_do_reg        <= cpu_do_next;
      cpu_ready_reg     <= cpu_ready_next;
      mem_addr_reg      <= mem_addr_next;
      mem_wdata_reg     <= mem_wdata_next;
      mem_en_reg        <= mem_en_next;
      mem_we_reg        <= mem_we_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    last_vid_next      = last_vid_reg;
    cnt_next           = cnt_reg;
    vdi_next           = vdi_reg;
    vram_complete_next = vram_complete_reg;
    cpu_do_next        = cpu_do_reg;
    cpu_ready_next     = cpu_ready_reg;
    mem_addr_next      = mem_addr_reg;
    mem_wdata_next     = mem_wdata_reg;
    mem_en_next        = mem_en_reg;
    mem_we_next        = mem_we_reg;

    case (state_reg)
      IDLE: begin
        // Video wins ties unless it had the previous grant.
        if (vram_cs && !(cpu_cs && last_vid_reg)) begin
          mem_addr_next = ADDR_W'(VAD);
          mem_en_next   = 1'b1;
          mem_we_next   = 1'b0;
          cnt_next      = CNT_INIT;
          last_vid_next = 1'b1;
          state_next    = VID_ACC;
        end else if (cpu_cs) begin
          mem_addr_next  = ADDR_W'(cpu_ad);
          mem_wdata_next = cpu_di;
          mem_en_next    = 1'b1;
          mem_we_next    = ~cpu_rw;
          cnt_next       = CNT_INIT;
          last_vid_next  = 1'b0;
          state_next     = CPU_ACC;
        end
      end
      VID_ACC: begin
        if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else begin
          vdi_next           = mem_rdata;
          vram_complete_next = 1'b1;
          mem_en_next        = 1'b0;
          state_next         = VID_DONE;
        end
      end
      VID_DONE: begin
        vram_complete_next = 1'b0;
        state_next         = IDLE;
      end
      CPU_ACC: begin
        if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else begin
          // Direction comes from the latched write enable; cpu_rw may have moved.
          if (!mem_we_reg) cpu_do_next = mem_rdata;
          cpu_ready_next = 1'b1;
          mem_en_next    = 1'b0;
          mem_we_next    = 1'b0;
          state_next     = CPU_DONE;
        end
      end
      CPU_DONE: begin
        cpu_ready_next = 1'b0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign vram_complete = vram_complete_reg;
  assign VDI           = vdi_reg;
  assign cpu_do        = cpu_do_reg;
  assign cpu_ready     = cpu_ready_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_en        = mem_en_reg;
  assign mem_we        = mem_we_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: transaction table at MEM_LAT=2, reset abort,
// contention, held video request, and MEM_LAT=1/7 latency builds.
module tb_vram_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] VAD = 16'h0000;
  logic        vram_cs = 1'b0;
  logic        vram_complete;
  logic [7:0]  VDI;
  logic [15:0] cpu_ad = 16'h0000;
  logic [7:0]  cpu_di = 8'h00;
  logic [7:0]  cpu_do;
  logic        cpu_rw = 1'b1;
  logic        cpu_cs = 1'b0;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_en;
  logic        mem_we;

  always #5 clk = ~clk;

  vram_arbiter #(.MEM_LAT(LAT), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .VAD(VAD), .vram_cs(vram_cs),
    .vram_complete(vram_complete), .VDI(VDI),
    .cpu_ad(cpu_ad), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_rw(cpu_rw),
    .cpu_cs(cpu_cs), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we)
  );

  // Behavioural single-port RAM: read data valid while mem_en is held.
  logic [7:0] mem [0:65535];
  assign mem_rdata = mem_en ? mem[mem_addr] : 8'h00;
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  // Latency builds: video only, read data derived from the address.
  logic        vcs1 = 1'b0, vcs7 = 1'b0;
  logic        cmp1, cmp7, rdy1, rdy7, en1, en7, we1, we7;
  logic [7:0]  vdi1, vdi7, cdo1, cdo7, wd1, wd7;
  logic [15:0] a1, a7;
  logic [7:0]  rd1, rd7;
  assign rd1 = en1 ? (a1[7:0] ^ 8'hA5) : 8'h00;
  assign rd7 = en7 ? (a7[7:0] ^ 8'hA5) : 8'h00;

  vram_arbiter #(.MEM_LAT(1), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .VAD(VAD), .vram_cs(vcs1),
    .vram_complete(cmp1), .VDI(vdi1),
    .cpu_ad(16'h0000), .cpu_di(8'h00), .cpu_do(cdo1), .cpu_rw(1'b1),
    .cpu_cs(1'b0), .cpu_ready(rdy1),
    .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(rd1),
    .mem_en(en1), .mem_we(we1)
  );

  vram_arbiter #(.MEM_LAT(7), .ADDR_W(16)) dut7 (
    .clk(clk), .rst(rst), .VAD(VAD), .vram_cs(vcs7),
    .vram_complete(cmp7), .VDI(vdi7),
    .cpu_ad(16'h0000), .cpu_di(8'h00), .cpu_do(cdo7), .cpu_rw(1'b1),
    .cpu_cs(1'b0), .cpu_ready(rdy7),
    .mem_addr(a7), .mem_wdata(wd7), .mem_rdata(rd7),
    .mem_en(en7), .mem_we(we7)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          cpu;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } txn_t;

  logic [7:0] exp_vdi = 8'h00;
  logic [7:0] exp_cpu_do = 8'h00;

  // Runs one access from IDLE and checks every cycle up to the DONE gap.
  task automatic do_txn(input txn_t t);
    logic want_we;
    want_we = t.cpu && !t.rw;
    @(negedge clk);
    if (t.cpu) begin
      cpu_ad = t.addr; cpu_di = t.wdata; cpu_rw = t.rw; cpu_cs = 1'b1;
    end else begin
      VAD = t.addr; vram_cs = 1'b1;
    end
    @(posedge clk); #1;
    check("grant_en", mem_en, 1'b1);
    check("grant_addr", mem_addr, t.addr);
    check("grant_we", mem_we, want_we);
    if (want_we) check("grant_wdata", mem_wdata, t.wdata);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (k < LAT) begin
        check("acc_en", mem_en, 1'b1);
        check("acc_we", mem_we, want_we);
        check("acc_vc", vram_complete, 1'b0);
        check("acc_rdy", cpu_ready, 1'b0);
      end else begin
        if (t.cpu) begin
          if (t.rw) exp_cpu_do = t.exp;
          check("cpu_ready", cpu_ready, 1'b1);
          check("cpu_do", cpu_do, exp_cpu_do);
          check("vc_idle", vram_complete, 1'b0);
        end else begin
          exp_vdi = t.exp;
          check("vram_complete", vram_complete, 1'b1);
          check("VDI", VDI, exp_vdi);
          check("rdy_idle", cpu_ready, 1'b0);
        end
        check("done_en", mem_en, 1'b0);
        check("done_we", mem_we, 1'b0);
      end
    end
    vram_cs = 1'b0; cpu_cs = 1'b0;
    @(posedge clk); #1;
    check("gap_vc", vram_complete, 1'b0);
    check("gap_rdy", cpu_ready, 1'b0);
    $display("txn cpu=%0d rw=%0d addr=%04h wdata=%02h exp=%02h VDI=%02h cpu_do=%02h",
             t.cpu, t.rw, t.addr, t.wdata, t.exp, VDI, cpu_do);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vc"}, vram_complete, 1'b0);
    check({tag, "_VDI"}, VDI, 8'h00);
    check({tag, "_cpu_do"}, cpu_do, 8'h00);
    check({tag, "_rdy"}, cpu_ready, 1'b0);
    check({tag, "_addr"}, mem_addr, 16'h0000);
    check({tag, "_wdata"}, mem_wdata, 8'h00);
    check({tag, "_en"}, mem_en, 1'b0);
    check({tag, "_we"}, mem_we, 1'b0);
  endtask

  task automatic restart(input logic v, input logic c);
    @(negedge clk);
    rst = 1'b1;
    vram_cs = v; cpu_cs = c;
    VAD = 16'h1234; cpu_ad = 16'h0100; cpu_rw = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  txn_t tbl [9];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'h5A;
    mem[16'hFFFF] = 8'h77;
    mem[16'h0000] = 8'h3C;

    tbl[0] = '{cpu: 1'b0, rw: 1'b1, addr: 16'h1234, wdata: 8'h00, exp: 8'h5A};
    tbl[1] = '{cpu: 1'b1, rw: 1'b0, addr: 16'h0100, wdata: 8'hC3, exp: 8'h00};
    tbl[2] = '{cpu: 1'b1, rw: 1'b1, addr: 16'h0100, wdata: 8'h00, exp: 8'hC3};
    tbl[3] = '{cpu: 1'b0, rw: 1'b1, addr: 16'h0100, wdata: 8'h00, exp: 8'hC3};
    tbl[4] = '{cpu: 1'b1, rw: 1'b0, addr: 16'h1234, wdata: 8'h11, exp: 8'h00};
    tbl[5] = '{cpu: 1'b0, rw: 1'b1, addr: 16'h1234, wdata: 8'h00, exp: 8'h11};
    tbl[6] = '{cpu: 1'b1, rw: 1'b1, addr: 16'h1234, wdata: 8'h00, exp: 8'h11};
    tbl[7] = '{cpu: 1'b0, rw: 1'b1, addr: 16'hFFFF, wdata: 8'h00, exp: 8'h77};
    tbl[8] = '{cpu: 1'b1, rw: 1'b1, addr: 16'h0000, wdata: 8'h00, exp: 8'h3C};

    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    // Reset in the middle of a CPU write aborts it with no late ready pulse.
    @(negedge clk);
    cpu_ad = 16'h0200; cpu_di = 8'h99; cpu_rw = 1'b0; cpu_cs = 1'b1;
    @(posedge clk); #1;
    check("rstw_we", mem_we, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    cpu_cs = 1'b0; cpu_rw = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("post_rst_rdy", cpu_ready, 1'b0);
      check("post_rst_en", mem_en, 1'b0);
    end
    exp_vdi = 8'h00; exp_cpu_do = 8'h00;
    do_txn(tbl[5]);
    $display("txn reset-abort sequence done");

    // Continuous contention: video, CPU, video, CPU with pulses 4 apart.
    restart(1'b1, 1'b1);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      check("cont_vc", vram_complete, (c % 8) == 2);
      check("cont_rdy", cpu_ready, (c % 8) == 6);
      if ((c % 8) == 2) check("cont_VDI", VDI, 8'h11);
      if ((c % 8) == 6) check("cont_cpu_do", cpu_do, 8'hC3);
    end
    vram_cs = 1'b0; cpu_cs = 1'b0;
    $display("txn contention sequence done");

    // Held video request: no re-grant in VID_DONE, only from IDLE.
    restart(1'b1, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("held_en", mem_en, (c % 4) < 2);
      check("held_vc", vram_complete, (c % 4) == 2);
    end
    vram_cs = 1'b0;
    $display("txn held-request sequence done");

    // MEM_LAT=1 and MEM_LAT=7 builds.
    restart(1'b0, 1'b0);
    @(negedge clk);
    VAD = 16'h00F0; vcs1 = 1'b1; vcs7 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      check("lat1_vc", cmp1, k == 1);
      check("lat7_vc", cmp7, k == 7);
      if (k == 0) begin
        check("lat1_en", en1, 1'b1);
        check("lat7_en", en7, 1'b1);
      end
      if (k == 1) begin
        check("lat1_VDI", vdi1, 8'h55);
        vcs1 = 1'b0;
      end
      if (k == 6) check("lat7_en_late", en7, 1'b1);
      if (k == 7) begin
        check("lat7_VDI", vdi7, 8'h55);
        vcs7 = 1'b0;
      end
    end
    $display("txn latency builds done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates a single-port video RAM between the video CRT controller's fetch port and the CPU bus. The video port supplies an address with a request strobe and expects a one-cycle completion pulse with read data. The CPU port is a stall-style 6800 bus slave. The block owns the memory's address, data and enable lines, and runs a small state machine that serialises accesses with bounded memory read latency.

## Interface
Parameters:
- MEM_LAT, 2, memory read latency in clocks from mem_en assertion to valid mem_rdata; legal 1..7
- ADDR_W, 16, memory address width

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- VAD  in  16  video fetch address; stable while vram_cs=1
- vram_cs  in  1  video read request, held until completion is sampled
- vram_complete  out  1  one-cycle pulse: VDI valid
- VDI  out  8  video read data
- cpu_ad  in  16  CPU address
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data
- cpu_rw  in  1  1=read, 0=write
- cpu_cs  in  1  CPU request, held until cpu_ready is seen
- cpu_ready  out  1  one-cycle pulse: CPU access finished
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable; only ever high together with mem_en

## Operation
- States: IDLE, VID_ACC, VID_DONE, CPU_ACC, CPU_DONE. Flag last_vid records whether the most recent grant went to video.
- IDLE grant rule:
  - vram_cs alone → video.
  - cpu_cs alone → CPU.
  - Both high → video, unless last_vid=1, in which case CPU. Strict alternation under contention, so neither side starves.
- Grant video: mem_addr<=VAD, mem_en<=1, mem_we<=0, cnt<=MEM_LAT-1, last_vid<=1, go to VID_ACC.
- VID_ACC, cnt≠0: cnt decrements.
- VID_ACC, cnt=0: VDI<=mem_rdata, vram_complete<=1, mem_en<=0, go to VID_DONE.
- VID_DONE: vram_complete<=0, go to IDLE. VID_DONE is a mandatory gap: the video side drops vram_cs on the same edge it samples completion, so vram_cs seen during VID_DONE is ignored.
- Grant CPU: mem_addr<=cpu_ad, mem_wdata<=cpu_di, mem_en<=1, mem_we<=~cpu_rw, cnt<=MEM_LAT-1, last_vid<=0, go to CPU_ACC.
- CPU_ACC follows the same count rules as VID_ACC. At cnt=0:
  - Read: cpu_do<=mem_rdata.
  - Write: cpu_do is unchanged.
  - Both: cpu_ready<=1, mem_en<=0, mem_we<=0, go to CPU_DONE.
- CPU_DONE: cpu_ready<=0, go to IDLE.
- VDI and cpu_do hold their last value until the next completion on their own port.
- A request that drops before its grant is simply never served. A request that drops mid-access is still completed; the pulse is issued regardless.
- cnt is 3 bits. Arithmetic is unsigned and does not wrap below 0 because the 0 case exits the state.

## Timing
- Reset (async assert): state=IDLE, last_vid=0, cnt=0. All outputs are 0: VAD-side VDI, vram_complete, cpu_do, cpu_ready, mem_addr, mem_wdata, mem_en, mem_we.
- Reset mid-access aborts the access. No completion pulse is issued after reset release.
- Latency: request sampled in IDLE at edge E0 → mem_en high from E0 → completion pulse high for exactly the cycle after edge E0+MEM_LAT.
  - MEM_LAT=2: pulse after E2; the requester samples it at E3.
- mem_rdata is sampled at edge E0+MEM_LAT.
- Service interval: minimum MEM_LAT+2 clocks per access (grant, MEM_LAT access edges, DONE gap).
- Worst-case wait for either port under continuous contention: one foreign access, i.e. 2·(MEM_LAT+2) clocks from request to own completion.
- mem_addr, mem_wdata and mem_we are stable for the whole time mem_en=1.

## Test plan
- Reset: assert rst mid CPU write with MEM_LAT=2 → every output reads 0 immediately; after release no cpu_ready pulse and state is IDLE.
- Video read: memory holds 0x5A at 0x1234; vram_cs=1, VAD=0x1234 at E0 → mem_en=1 and mem_addr=0x1234 after E0; vram_complete=1 and VDI=0x5A after E2 only; vram_complete=0 after E3.
- CPU write then read: write 0xC3 to 0x0100 → mem_we=1 for 2 cycles, cpu_ready pulse after E2. Read back 0x0100 → cpu_do=0xC3 with cpu_ready, mem_we stays 0.
- Contention: vram_cs and cpu_cs held high continuously from reset → grants alternate video, CPU, video, CPU; completion pulses spaced 4 clocks apart.
- Held request: vram_cs stays high through VID_DONE → no second access starts in VID_DONE; a second grant occurs only from IDLE.
- MEM_LAT=1 and MEM_LAT=7 builds → completion after E1 and E7 respectively; data sampled correctly in both.
